// File: rtl/plic_pkg.sv
// Shared types and trigger constants for the PLIC interrupt gateway.
package plic_pkg;

   typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_ACTIVE} plic_gw_state_e;

   localparam logic PLIC_EDGE  = 1'b1;
   localparam logic PLIC_LEVEL = 1'b0;

endpackage

// File: rtl/plic_gateway_unit.sv
// Single-source gateway: input synchroniser, rising-edge detect, saturating edge counter
// and IDLE/PEND/ACTIVE claim life cycle.
module plic_gateway_unit
   import plic_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned EDGE_CNT_BIT = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic test_mode_i,
   input  logic src_i,
   input  logic edge_i,
   input  logic claim_hit_i,
   input  logic cmpl_hit_i,
   output logic pend_o,
   output logic active_o
);

   localparam int unsigned SUM_W = EDGE_CNT_BIT + 1;
   localparam logic [EDGE_CNT_BIT-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    s_c;
   logic                    s_q;
   logic                    rise_c;
   logic                    consume_c;
   logic [EDGE_CNT_BIT-1:0] cnt_q;
   logic [EDGE_CNT_BIT-1:0] cnt_nxt_c;
   logic [SUM_W-1:0]        cnt_sum_c;
   plic_gw_state_e          state_q;

   // Synchroniser shift chain plus one-cycle history for edge detection
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= '0;
         s_q    <= 1'b0;
      end else begin
         sync_q <= (sync_q << 1) | SYNC_STAGES'(src_i);
         s_q    <= s_c;
      end
   end

   assign s_c    = test_mode_i ? src_i : sync_q[SYNC_STAGES-1];
   assign rise_c = s_c & ~s_q;

   // Request evaluation and counter arithmetic; a same-cycle rise and consume cancel out
   always_comb begin
      consume_c = 1'b0;
      if (state_q == GW_IDLE) begin
         consume_c = (edge_i == PLIC_EDGE) ? ((cnt_q != '0) | rise_c) : s_c;
      end
      cnt_sum_c = {1'b0, cnt_q} + SUM_W'(rise_c) - SUM_W'(consume_c);
      cnt_nxt_c = cnt_sum_c[EDGE_CNT_BIT] ? CNT_MAX : cnt_sum_c[EDGE_CNT_BIT-1:0];
      if (edge_i == PLIC_LEVEL) begin
         cnt_nxt_c = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= GW_IDLE;
         cnt_q    <= '0;
         pend_o   <= 1'b0;
         active_o <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt_c;
         case (state_q)
            GW_IDLE: begin
               if (consume_c) begin
                  state_q <= GW_PEND;
                  pend_o  <= 1'b1;
               end
            end
            GW_PEND: begin
               if (claim_hit_i) begin
                  state_q  <= GW_ACTIVE;
                  pend_o   <= 1'b0;
                  active_o <= 1'b1;
               end
            end
            GW_ACTIVE: begin
               if (cmpl_hit_i) begin
                  state_q  <= GW_IDLE;
                  active_o <= 1'b0;
               end
            end
            default: begin
               state_q  <= GW_IDLE;
               pend_o   <= 1'b0;
               active_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/plic_irq_gateway.sv
// Array of per-source gateways feeding the PLIC arbitration tree; source 0 is reserved.
module plic_irq_gateway
   import plic_pkg::*;
#(
   parameter int unsigned NUM_IRQ      = 512,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned EDGE_CNT_BIT = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       test_mode_i,
   input  logic [NUM_IRQ-1:0]         irq_src_i,
   input  logic [NUM_IRQ-1:0]         irq_edge_i,
   input  logic                       claim_vld_i,
   input  logic [$clog2(NUM_IRQ)-1:0] claim_id_i,
   input  logic                       cmpl_vld_i,
   input  logic [$clog2(NUM_IRQ)-1:0] cmpl_id_i,
   output logic [NUM_IRQ-1:0]         irq_pend_o,
   output logic [NUM_IRQ-1:0]         irq_active_o
);

   localparam int unsigned ID_W = $clog2(NUM_IRQ);

   logic [NUM_IRQ-1:1] claim_hit;
   logic [NUM_IRQ-1:1] cmpl_hit;
   logic               unused_src0;

   // ID 0 and out-of-range IDs match no decoder output, so they are ignored
   for (genvar n = 1; n < NUM_IRQ; n++) begin : g_dec
      assign claim_hit[n] = claim_vld_i && (claim_id_i == ID_W'(n));
      assign cmpl_hit[n]  = cmpl_vld_i && (cmpl_id_i == ID_W'(n));
   end

   assign irq_pend_o[0]   = 1'b0;
   assign irq_active_o[0] = 1'b0;
   assign unused_src0     = irq_src_i[0] ^ irq_edge_i[0];

   for (genvar n = 1; n < NUM_IRQ; n++) begin : g_src
      plic_gateway_unit #(
         .SYNC_STAGES  (SYNC_STAGES),
         .EDGE_CNT_BIT (EDGE_CNT_BIT)
      ) u_unit (
         .clk_i       (clk_i),
         .rst_n_i     (rst_n_i),
         .test_mode_i (test_mode_i),
         .src_i       (irq_src_i[n]),
         .edge_i      (irq_edge_i[n]),
         .claim_hit_i (claim_hit[n]),
         .cmpl_hit_i  (cmpl_hit[n]),
         .pend_o      (irq_pend_o[n]),
         .active_o    (irq_active_o[n])
      );
   end

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Randomised and directed bench for plic_irq_gateway against a behavioural gateway model.
module tb_plic_irq_gateway;

   localparam int N    = 20;
   localparam int SS   = 2;
   localparam int CW   = 2;
   localparam int IDW  = $clog2(N);
   localparam int CMAX = (1 << CW) - 1;

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic           test_mode = 1'b0;
   logic [N-1:0]   src       = '0;
   logic [N-1:0]   edge_cfg  = '0;
   logic           claim_vld = 1'b0;
   logic [IDW-1:0] claim_id  = '0;
   logic           cmpl_vld  = 1'b0;
   logic [IDW-1:0] cmpl_id   = '0;
   logic [N-1:0]   pend;
   logic [N-1:0]   active;

   int total  = 0;
   int passed = 0;
   bit chk_on = 1'b0;

   plic_irq_gateway #(
      .NUM_IRQ      (N),
      .SYNC_STAGES  (SS),
      .EDGE_CNT_BIT (CW)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .test_mode_i  (test_mode),
      .irq_src_i    (src),
      .irq_edge_i   (edge_cfg),
      .claim_vld_i  (claim_vld),
      .claim_id_i   (claim_id),
      .cmpl_vld_i   (cmpl_vld),
      .cmpl_id_i    (cmpl_id),
      .irq_pend_o   (pend),
      .irq_active_o (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Behavioural model: what each source has seen, how many edges it owes, and where it is
   bit m_pend  [N];
   bit m_act   [N];
   int m_cnt   [N];
   bit m_pipe  [N][SS];
   bit m_sprev [N];

   always @(posedge clk or negedge rst_n) begin
      bit s, rise, idle, req, take;
      int c;
      if (!rst_n) begin
         for (int n = 0; n < N; n++) begin
            m_pend[n]  <= 1'b0;
            m_act[n]   <= 1'b0;
            m_cnt[n]   <= 0;
            m_sprev[n] <= 1'b0;
            for (int k = 0; k < SS; k++) m_pipe[n][k] <= 1'b0;
         end
      end else begin
         for (int n = 1; n < N; n++) begin
            s    = test_mode ? src[n] : m_pipe[n][SS-1];
            rise = s && !m_sprev[n];
            idle = !m_pend[n] && !m_act[n];
            req  = edge_cfg[n] ? (m_cnt[n] > 0 || rise) : s;
            take = idle && req;
            c    = m_cnt[n];
            if (edge_cfg[n]) begin
               if (rise && !take) c = (c < CMAX) ? c + 1 : c;
               else if (take && !rise) c = c - 1;
            end else begin
               c = 0;
            end
            m_cnt[n] <= c;
            if (take) m_pend[n] <= 1'b1;
            else if (m_pend[n] && claim_vld && claim_id == IDW'(n)) begin
               m_pend[n] <= 1'b0;
               m_act[n]  <= 1'b1;
            end else if (m_act[n] && cmpl_vld && cmpl_id == IDW'(n)) begin
               m_act[n] <= 1'b0;
            end
            for (int k = SS - 1; k > 0; k--) m_pipe[n][k] <= m_pipe[n][k-1];
            m_pipe[n][0] <= src[n];
            m_sprev[n]   <= s;
         end
      end
   end

   function automatic logic [N-1:0] model_pend();
      logic [N-1:0] v = '0;
      for (int n = 0; n < N; n++) v[n] = m_pend[n];
      return v;
   endfunction

   function automatic logic [N-1:0] model_act();
      logic [N-1:0] v = '0;
      for (int n = 0; n < N; n++) v[n] = m_act[n];
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_pend_vec", 32'(pend), 32'(model_pend()));
         chk("model_active_vec", 32'(active), 32'(model_act()));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic claim(input int id);
      claim_vld = 1'b1;
      claim_id  = IDW'(id);
      step(1);
      claim_vld = 1'b0;
   endtask

   task automatic cmpl(input int id);
      cmpl_vld = 1'b1;
      cmpl_id  = IDW'(id);
      step(1);
      cmpl_vld = 1'b0;
   endtask

   task automatic pulses(input int idx, input int cnt);
      repeat (cnt) begin
         src[idx] = 1'b1;
         step(1);
         src[idx] = 1'b0;
         step(1);
      end
   endtask

   task automatic rand_phase(input int cycles, input bit tm);
      test_mode = tm;
      edge_cfg  = N'($urandom);
      repeat (cycles) begin
         step(1);
         for (int n = 0; n < N; n++) if ($urandom_range(0, 5) == 0) src[n] = ~src[n];
         claim_vld = ($urandom_range(0, 1) == 0);
         claim_id  = IDW'($urandom_range(0, 23));
         cmpl_vld  = ($urandom_range(0, 1) == 0);
         cmpl_id   = IDW'($urandom_range(0, 23));
      end
      step(1);
      claim_vld = 1'b0;
      cmpl_vld  = 1'b0;
   endtask

   initial begin
      edge_cfg[9] = 1'b1;
      step(2);
      rst_n  = 1'b1;
      chk_on = 1'b1;
      chk("reset_pend", 32'(pend), 32'd0);
      chk("reset_active", 32'(active), 32'd0);

      // Level source: three-cycle latency, claim, complete with line still high
      src[5] = 1'b1;
      step(2);
      chk("lvl_pend_cyc2", 32'(pend[5]), 32'd0);
      step(1);
      chk("lvl_pend_cyc3", 32'(pend[5]), 32'd1);
      claim(5);
      chk("lvl_claim_pend", 32'(pend[5]), 32'd0);
      chk("lvl_claim_active", 32'(active[5]), 32'd1);
      cmpl(5);
      chk("lvl_cmpl_idle", 32'({active[5], pend[5]}), 32'd0);
      step(1);
      chk("lvl_repend", 32'(pend[5]), 32'd1);

      // Edge source: three pulses give three pends
      pulses(9, 3);
      step(4);
      for (int r = 0; r < 4; r++) begin
         chk("edge3_round_pend", 32'(pend[9]), 32'(r < 3));
         claim(9);
         cmpl(9);
         step(1);
      end

      // Edge counter saturates: six pulses give four pends
      pulses(9, 6);
      step(4);
      for (int r = 0; r < 5; r++) begin
         chk("edge_sat_round_pend", 32'(pend[9]), 32'(r < 4));
         claim(9);
         cmpl(9);
         step(1);
      end

      // Test mode bypasses the synchroniser
      test_mode = 1'b1;
      src[15]   = 1'b1;
      step(1);
      chk("testmode_latency", 32'(pend[15]), 32'd1);
      test_mode = 1'b0;

      // Ignored claims/completes
      src[12] = 1'b1;
      step(3);
      claim(7);
      chk("claim_idle_ignored", 32'({active[7], pend[7]}), 32'd0);
      claim(0);
      cmpl(12);
      claim(N);
      cmpl(N);
      chk("cmpl_pend_ignored", 32'({active[12], pend[12]}), 32'd1);

      // Claim and complete of different IDs in one cycle
      src[3] = 1'b1;
      src[4] = 1'b1;
      step(3);
      claim(4);
      claim_vld = 1'b1;
      claim_id  = IDW'(3);
      cmpl_vld  = 1'b1;
      cmpl_id   = IDW'(4);
      step(1);
      claim_vld = 1'b0;
      cmpl_vld  = 1'b0;
      chk("dual_active3", 32'(active[3]), 32'd1);
      chk("dual_active4", 32'(active[4]), 32'd0);

      rand_phase(800, 1'b0);
      rand_phase(400, 1'b1);
      rand_phase(800, 1'b0);

      // Asynchronous reset mid-operation, then silence until a fresh edge
      src = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_pend", 32'(pend), 32'd0);
      chk("async_rst_active", 32'(active), 32'd0);
      step(2);
      rst_n     = 1'b1;
      test_mode = 1'b0;
      edge_cfg  = '1;
      step(6);
      chk("post_rst_pend", 32'(pend), 32'd0);
      chk("post_rst_active", 32'(active), 32'd0);
      src[9] = 1'b1;
      step(3);
      chk("post_rst_new_edge", 32'(pend), 32'(1 << 9));
      step(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
